// File: rtl/led_pkg.sv
// Shared definitions for the LED chaser: mode encodings and the speed-to-period shift.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_ROTATE = 2'b00,
        MODE_BOUNCE = 2'b01,
        MODE_FILL   = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_t;

    // Slowest speed (00) uses the longest period: BASE_TICKS << 3.
    function automatic logic [1:0] speed_shift(input logic [1:0] speed);
        return 2'd3 - speed;
    endfunction

endpackage

// File: rtl/led_chaser_gen_tick_gen.sv
// Period counter: counts 0..period-1 while enabled and emits a registered one-cycle step.
module tick_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] period,
    output logic        step
);

    logic [31:0] count;

    // ">=" lets a shortened period take effect at once when count is already past it.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 32'd0;
            step  <= 1'b0;
        end else begin
            step <= 1'b0;
            if (en) begin
                if (count >= period - 32'd1) begin
                    count <= 32'd0;
                    step  <= 1'b1;
                end else begin
                    count <= count + 32'd1;
                end
            end
        end
    end

endmodule

// File: rtl/led_chaser_gen.sv
// LED pattern generator: rotate, bounce, fill or hold, stepped by a programmable period.
module led_chaser_gen
    import led_pkg::*;
#(
    parameter int N_LED      = 8,
    parameter int BASE_TICKS = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       speed,
    input  logic [1:0]       mode,
    input  logic             dir,
    output logic [N_LED-1:0] led,
    output logic             tick
);

    localparam logic [N_LED-1:0] LED_ONE = {{(N_LED-1){1'b0}}, 1'b1};

    mode_t       mode_in;
    mode_t       mode_r;
    logic        mode_change;
    logic        bounce_up;
    logic        step;
    logic [31:0] period;

    assign mode_in     = mode_t'(mode);
    assign mode_change = (mode_in != mode_r);
    assign period      = 32'(BASE_TICKS) << speed_shift(speed);

    function automatic logic [N_LED-1:0] rotate_next(input logic [N_LED-1:0] p, input logic d);
        return d ? {p[N_LED-2:0], p[N_LED-1]} : {p[0], p[N_LED-1:1]};
    endfunction

    // Sets the lowest (d=1) or highest (d=0) clear bit; a full bar empties.
    function automatic logic [N_LED-1:0] fill_next(input logic [N_LED-1:0] p, input logic d);
        logic [N_LED-1:0] r;
        logic             found;
        r     = p;
        found = 1'b0;
        if (&p) begin
            r = '0;
        end else if (d) begin
            r = p | (p + 1'b1);
        end else begin
            for (int i = N_LED - 1; i >= 0; i--) begin
                if (!found && !p[i]) begin
                    r[i]  = 1'b1;
                    found = 1'b1;
                end
            end
        end
        return r;
    endfunction

    // A mode change resets the counter too, so a pending step is discarded.
    tick_gen u_tick_gen (
        .clk    (clk),
        .rst    (rst | mode_change),
        .en     (en && (mode_r != MODE_HOLD)),
        .period (period),
        .step   (step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            led       <= LED_ONE;
            tick      <= 1'b0;
            bounce_up <= 1'b1;
            mode_r    <= MODE_ROTATE;
        end else if (mode_change) begin
            mode_r    <= mode_in;
            tick      <= 1'b0;
            bounce_up <= 1'b1;
            case (mode_in)
                MODE_ROTATE, MODE_BOUNCE: led <= LED_ONE;
                MODE_FILL:                led <= '0;
                default:                  led <= led;
            endcase
        end else begin
            tick <= step;
            if (step) begin
                case (mode_r)
                    MODE_ROTATE: led <= rotate_next(led, dir);
                    MODE_BOUNCE: begin
                        if (bounce_up) begin
                            led <= led << 1;
                            if (led[N_LED-2]) bounce_up <= 1'b0;
                        end else begin
                            led <= led >> 1;
                            if (led[1]) bounce_up <= 1'b1;
                        end
                    end
                    MODE_FILL:   led <= fill_next(led, dir);
                    default:     led <= led;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_chaser_gen.sv
// Self-checking bench for led_chaser_gen (N_LED=8, BASE_TICKS=2): vector table, corner sequences, random vs model.
module tb_led_chaser_gen;

    logic       clk = 1'b0;
    logic       rst, en, dir;
    logic [1:0] speed, mode;
    logic [7:0] led;
    logic       tick;

    int n_chk  = 0;
    int n_fail = 0;

    led_chaser_gen #(.N_LED(8), .BASE_TICKS(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .speed (speed),
        .mode  (mode),
        .dir   (dir),
        .led   (led),
        .tick  (tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] speed;
        logic [1:0] mode;
        logic       dir;
        logic [7:0] led;
        logic       tick;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mkv(logic r, logic e, logic [1:0] s, logic [1:0] m, logic d,
                                 logic [7:0] l, logic t);
        vec_t v;
        v.rst = r; v.en = e; v.speed = s; v.mode = m; v.dir = d; v.led = l; v.tick = t;
        return v;
    endfunction

    task automatic clk1;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_tick(input int maxc, output int n);
        n = 0;
        do begin
            clk1;
            n++;
        end while (!tick && n < maxc);
        check("tick_within_budget", {31'd0, tick}, 32'd1);
    endtask

    task automatic start(input logic [1:0] s, input logic [1:0] m, input logic d);
        rst = 1'b1; en = 1'b1; speed = s; mode = 2'b00; dir = d;
        clk1;
        rst = 1'b0; mode = m;
    endtask

    // Reference model: positions and bar fill computed arithmetically.
    logic [7:0] m_led;
    logic       m_tick;
    int         m_mode, m_cnt, m_rpos, m_bph;
    bit         m_pend;

    function automatic logic [7:0] fill_ref(logic [7:0] p, logic d);
        logic [7:0] r = p;
        bit done = 0;
        if (p == 8'hFF) return 8'h00;
        for (int i = 0; i < 8; i++) begin
            int b = d ? i : 7 - i;
            if (!done && !p[b]) begin r[b] = 1'b1; done = 1; end
        end
        return r;
    endfunction

    task automatic model_edge(input logic r, input logic e, input logic [1:0] s,
                              input logic [1:0] m, input logic d);
        int p;
        int pos;
        p = 2 << (3 - int'(s));
        if (r) begin
            m_led = 8'h01; m_tick = 0; m_mode = 0; m_cnt = 0; m_pend = 0; m_rpos = 0; m_bph = 0;
        end else if (int'(m) != m_mode) begin
            m_mode = int'(m); m_cnt = 0; m_pend = 0; m_tick = 0;
            if (m_mode == 0) begin m_rpos = 0; m_led = 8'h01; end
            else if (m_mode == 1) begin m_bph = 0; m_led = 8'h01; end
            else if (m_mode == 2) m_led = 8'h00;
        end else begin
            m_tick = m_pend;
            if (m_pend) begin
                if (m_mode == 0) begin
                    m_rpos = (m_rpos + (d ? 1 : 7)) % 8;
                    m_led  = 8'(1 << m_rpos);
                end else if (m_mode == 1) begin
                    m_bph = (m_bph + 1) % 14;
                    pos   = (m_bph < 8) ? m_bph : 14 - m_bph;
                    m_led = 8'(1 << pos);
                end else if (m_mode == 2) begin
                    m_led = fill_ref(m_led, d);
                end
            end
            m_pend = 0;
            if (e && m_mode != 3) begin
                if (m_cnt >= p - 1) begin m_cnt = 0; m_pend = 1; end
                else m_cnt++;
            end
        end
    endtask

    initial begin
        int n;
        logic [7:0]  e8;
        logic [15:0] t16;

        rst = 1'b1; en = 1'b0; speed = 2'd3; mode = 2'd0; dir = 1'b1;

        // Vector table: reset, rotate, mode change with pending step, fill, reset mid-fill, hold
        vecs[0]  = mkv(1, 1, 3, 0, 1, 8'h01, 0);
        vecs[1]  = mkv(0, 1, 3, 0, 1, 8'h01, 0);
        vecs[2]  = mkv(0, 1, 3, 0, 1, 8'h01, 0);
        vecs[3]  = mkv(0, 1, 3, 0, 1, 8'h02, 1);
        vecs[4]  = mkv(0, 1, 3, 0, 1, 8'h02, 0);
        vecs[5]  = mkv(0, 1, 3, 0, 1, 8'h04, 1);
        vecs[6]  = mkv(0, 1, 3, 0, 1, 8'h04, 0);
        vecs[7]  = mkv(0, 1, 3, 0, 1, 8'h08, 1);
        vecs[8]  = mkv(0, 1, 3, 0, 1, 8'h08, 0);
        vecs[9]  = mkv(0, 1, 3, 0, 1, 8'h10, 1);
        vecs[10] = mkv(0, 1, 3, 0, 1, 8'h10, 0);
        vecs[11] = mkv(0, 1, 3, 2, 0, 8'h00, 0);
        vecs[12] = mkv(0, 1, 3, 2, 0, 8'h00, 0);
        vecs[13] = mkv(0, 1, 3, 2, 0, 8'h00, 0);
        vecs[14] = mkv(0, 1, 3, 2, 0, 8'h80, 1);
        vecs[15] = mkv(0, 1, 3, 2, 0, 8'h80, 0);
        vecs[16] = mkv(0, 1, 3, 2, 0, 8'hC0, 1);
        vecs[17] = mkv(1, 1, 3, 2, 0, 8'h01, 0);
        vecs[18] = mkv(0, 1, 3, 0, 1, 8'h01, 0);
        vecs[19] = mkv(0, 1, 3, 3, 1, 8'h01, 0);
        vecs[20] = mkv(0, 1, 3, 3, 1, 8'h01, 0);
        vecs[21] = mkv(0, 1, 3, 3, 1, 8'h01, 0);

        for (int i = 0; i < 22; i++) begin
            rst = vecs[i].rst; en = vecs[i].en; speed = vecs[i].speed;
            mode = vecs[i].mode; dir = vecs[i].dir;
            clk1;
            check($sformatf("vec%0d_led", i), {24'd0, led}, {24'd0, vecs[i].led});
            check($sformatf("vec%0d_tick", i), {31'd0, tick}, {31'd0, vecs[i].tick});
        end

        // Bounce: 01..80..01,02 with each end shown once
        start(2'd3, 2'd1, 1'b1);
        clk1;
        check("bounce_init", {24'd0, led}, 32'h01);
        for (int k = 1; k < 16; k++) begin
            int ph;
            ph = k % 14;
            e8 = 8'(1 << ((ph < 8) ? ph : 14 - ph));
            wait_tick(8, n);
            check($sformatf("bounce_step%0d", k), {24'd0, led}, {24'd0, e8});
            if (k > 1) check($sformatf("bounce_gap%0d", k), n, 2);
        end

        // Fill from MSB: 80,C0,...,FF,00,80
        start(2'd3, 2'd2, 1'b0);
        clk1;
        check("fill_init", {24'd0, led}, 32'h00);
        for (int k = 1; k <= 10; k++) begin
            t16 = 16'hFF00 >> (k % 9);
            wait_tick(8, n);
            check($sformatf("fill_step%0d", k), {24'd0, led}, {24'd0, t16[7:0]});
        end

        // Speed change from period 16 to 2 at count 10
        start(2'd0, 2'd0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            clk1;
            check($sformatf("slow_notick%0d", k), {31'd0, tick}, 32'd0);
        end
        speed = 2'd3;
        clk1;
        check("speedchg_wrap_cycle", {31'd0, tick}, 32'd0);
        clk1;
        check("speedchg_tick", {31'd0, tick}, 32'd1);
        check("speedchg_led", {24'd0, led}, 32'h02);
        wait_tick(8, n);
        check("speedchg_gap", n, 2);
        check("speedchg_led2", {24'd0, led}, 32'h04);

        // Pause for 7 cycles at count 5 of a 16-cycle period
        start(2'd0, 2'd0, 1'b1);
        for (int k = 0; k < 5; k++) clk1;
        en = 1'b0;
        for (int k = 0; k < 7; k++) begin
            clk1;
            check($sformatf("pause_led%0d", k), {24'd0, led}, 32'h01);
            check($sformatf("pause_tick%0d", k), {31'd0, tick}, 32'd0);
        end
        en = 1'b1;
        wait_tick(30, n);
        check("pause_resume_gap", n, 12);
        check("pause_resume_led", {24'd0, led}, 32'h02);

        // Randomized run against the reference model
        rst = 1'b1; en = 1'b1; speed = 2'd3; mode = 2'd0; dir = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if (c > 0) begin
                rst = ($urandom_range(0, 299) == 0);
                en  = ($urandom_range(0, 7) != 0);
                if ($urandom_range(0, 24) == 0) speed = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 79) == 0) mode  = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 19) == 0) dir   = 1'($urandom_range(0, 1));
            end
            model_edge(rst, en, speed, mode, dir);
            clk1;
            check($sformatf("rand%0d_led", c), {24'd0, led}, {24'd0, m_led});
            check($sformatf("rand%0d_tick", c), {31'd0, tick}, {31'd0, m_tick});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/led_chaser_gen.md
LED_CHASER_GEN -- requirements
Module: led_chaser_gen

Interface
REQ-001 Parameter N_LED, default 8: number of LED outputs, legal range 4..32.
REQ-002 Parameter BASE_TICKS, default 50_000_000: step period in clk cycles at the fastest speed, legal range 2..2^28.
REQ-003 clk  input  1: single clock; all logic is on the rising edge.
REQ-004 rst  input  1: reset, synchronous, active-high.
REQ-005 en  input  1: 1 = run, 0 = pause; counter and pattern hold.
REQ-006 speed  input  2: step period select.
REQ-007 mode  input  2: 00 ROTATE, 01 BOUNCE, 10 FILL, 11 HOLD.
REQ-008 dir  input  1: 1 = toward MSB, 0 = toward LSB; ignored in BOUNCE.
REQ-009 led  output  N_LED: registered LED pattern.
REQ-010 tick  output  1: registered one-cycle pulse on each pattern step.

Function
REQ-011 Step period P SHALL be BASE_TICKS << (3 - speed): speed 00 gives 8x, 01 gives 4x, 10 gives 2x, 11 gives 1x BASE_TICKS.
REQ-012 The 32-bit counter SHALL count 0..P-1 while en=1 and mode!=HOLD; a step SHALL occur when count==P-1, so steps are exactly P cycles apart.
REQ-013 On a speed change mid-period, if count >= new P-1 the counter SHALL step on the next enabled cycle and restart at 0; otherwise it SHALL continue counting to the new P-1.
REQ-014 In ROTATE, the initial pattern SHALL be LSB one-hot; each step SHALL rotate by one bit with wrap-around, left when dir=1 and right when dir=0.
REQ-015 In BOUNCE, the initial pattern SHALL be LSB one-hot with internal direction up; each step SHALL shift by one bit.
REQ-016 In BOUNCE, on reaching the MSB the direction SHALL become down, and on reaching the LSB it SHALL become up; no end position is held for two steps.
REQ-017 In FILL with dir=1, the initial pattern SHALL be all zeros; each step SHALL set the next bit from the LSB; the step after all ones SHALL give all zeros; this cycle SHALL repeat.
REQ-018 In FILL with dir=0, the behaviour SHALL be the same as REQ-017 but filling from the MSB.
REQ-019 In HOLD, led SHALL be frozen, the counter SHALL be frozen, and tick SHALL stay 0.
REQ-020 A mode change (registered mode != new mode) SHALL do three things on the next cycle: load the new mode's initial pattern, clear the counter, and not assert tick.
REQ-021 Entering HOLD SHALL keep the current pattern.
REQ-022 A dir change SHALL NOT reload the pattern; it takes effect at the next step.
REQ-023 A FILL dir change mid-fill SHALL continue from the current pattern, setting the lowest (or highest) zero bit.
REQ-024 en=0 SHALL freeze counter and pattern without loss; a mode change during en=0 SHALL still reload per REQ-020.
REQ-025 tick SHALL assert in the same cycle that led updates on a step.
REQ-026 led SHALL never be all zeros in ROTATE or BOUNCE.

Reset
REQ-027 While rst=1 at a clock edge: led SHALL be 1 (LSB one-hot), tick 0, counter 0, bounce direction up, registered mode ROTATE.
REQ-028 Reset asserted mid-period or mid-fill SHALL take effect at that edge with no partial step.
REQ-029 The first step after reset deassertion SHALL occur P cycles after the first enabled cycle.

Structure
REQ-030 The mode encodings and the speed-to-shift mapping SHALL live in shared package led_pkg.
REQ-031 The period counter SHALL be a sub-module, tick_gen, with ports clk, rst, en, period[31:0], and a registered step output.
REQ-032 Pattern logic SHALL be one clocked process in led_chaser_gen.
REQ-033 No combinational path SHALL exist from any input to led or tick.

Verification (N_LED=8, BASE_TICKS=2)
REQ-034 Reset, ROTATE, dir=1, speed=11 -> led 01,02,04,...,80,01 with tick every 2 cycles.
REQ-035 BOUNCE, speed=11, 16 steps -> 01,02,...,80,40,...,01,02; 80 and 01 each appear once per turn.
REQ-036 FILL, dir=0 -> 80,C0,E0,...,FF,00,80.
REQ-037 speed=00 running; switch to speed=11 at count=10 -> step on the next enabled cycle, then every 2 cycles.
REQ-038 en=0 for 7 cycles mid-period -> led, count and tick frozen; step resumes exactly the remaining cycles later.
REQ-039 Mode ROTATE->FILL at led=10 -> led=00 the next cycle, no tick; rst=1 mid-FILL -> led=01 at that edge.
